// File: rtl/rtc_reset_pkg.sv
// Shared constants for the reset sequencer: FSM state codes, reset-cause codes and default timing.
package rtc_reset_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_HOLD_CYCLES     = 1024;
    localparam int unsigned DEF_STAGE_GAP       = 16;
    localparam int unsigned DEF_WDT_CYCLES      = 1 << 20;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CAUSE_W = 2;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [CAUSE_W-1:0] cause_t;

    localparam state_t ST_ASSERT      = 3'd0;
    localparam state_t ST_WAIT_LOCK   = 3'd1;
    localparam state_t ST_HOLD        = 3'd2;
    localparam state_t ST_REL_CORE    = 3'd3;
    localparam state_t ST_REL_PERIPH  = 3'd4;
    localparam state_t ST_REL_DISPLAY = 3'd5;
    localparam state_t ST_RUN         = 3'd6;

    localparam cause_t CAUSE_EXT = 2'd0;
    localparam cause_t CAUSE_BTN = 2'd1;
    localparam cause_t CAUSE_SW  = 2'd2;
    localparam cause_t CAUSE_WDT = 2'd3;

    // Cause of an accepted request; caller guarantees at least one source is active.
    function automatic cause_t pick_cause(input logic wdt, input logic btn);
        if (wdt) begin
            return CAUSE_WDT;
        end
        if (btn) begin
            return CAUSE_BTN;
        end
        return CAUSE_SW;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-FF synchronizer, stability counter, one-cycle pulse on a debounced rising edge.
module btn_debounce
    import rtc_reset_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic btn_req
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q, sync2_q, last_q;
    logic            level_q, level_d;
    logic            req_q, req_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Counter restarts on any change; level follows the input once it has been steady long enough.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q != last_q) begin
            cnt_d = '0;
        end else if (cnt_q != DB_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d = cnt_q + DB_W'(1);
        end
        if ((sync2_q == last_q) && (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1))) begin
            level_d = last_q;
        end
        req_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            level_q <= 1'b0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_async;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            level_q <= level_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_req = req_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release (core, periph, display) with button, software, lock-loss and watchdog restarts.
// Define RESET_SEQ_WDT_EN to build the RUN-state watchdog.
module reset_sequencer
    import rtc_reset_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
    parameter int unsigned WDT_CYCLES      = DEF_WDT_CYCLES
) (
    input  logic               clk,
    input  logic               ext_reset,
    input  logic               btn_reset,
    input  logic               sw_reset_req,
    input  logic               pll_locked,
    input  logic               wdt_kick,
    output logic               rst_core,
    output logic               rst_periph,
    output logic               rst_display,
    output logic               seq_done,
    output logic [CAUSE_W-1:0] reset_cause
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_core_q, rst_core_d;
    logic             rst_periph_q, rst_periph_d;
    logic             rst_display_q, rst_display_d;
    logic             seq_done_q, seq_done_d;
    logic             btn_req, wdt_fire, take_req, asserting, enter;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (ext_reset),
        .btn_async(btn_reset),
        .btn_req  (btn_req)
    );

`ifdef RESET_SEQ_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

    // Counts unkicked RUN cycles; fires on the last cycle of the timeout window.
    always_comb begin
        wdt_cnt_d = '0;
        if ((state_q == ST_RUN) && !wdt_kick && (wdt_cnt_q != WDT_W'(WDT_CYCLES - 1))) begin
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end else if ((state_q == ST_RUN) && !wdt_kick) begin
            wdt_cnt_d = wdt_cnt_q;
        end
    end

    assign wdt_fire = (state_q == ST_RUN) && !wdt_kick && (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge ext_reset) begin
        if (ext_reset) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
        end
    end
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
    assign wdt_fire   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        take_req = (state_q != ST_ASSERT) && (wdt_fire || btn_req || sw_reset_req);
        if (take_req) begin
            state_d = ST_WAIT_LOCK;
            cause_d = pick_cause(wdt_fire, btn_req);
        end else if (!pll_locked && (state_q inside {ST_HOLD, ST_REL_CORE, ST_REL_PERIPH,
                                                      ST_REL_DISPLAY, ST_RUN})) begin
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_ASSERT:      state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK:   if (pll_locked) state_d = ST_HOLD;
                ST_HOLD:        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = ST_REL_CORE;
                ST_REL_CORE:    if (cnt_q == CNT_W'(STAGE_GAP - 1)) state_d = ST_REL_PERIPH;
                ST_REL_PERIPH:  if (cnt_q == CNT_W'(STAGE_GAP - 1)) state_d = ST_REL_DISPLAY;
                ST_REL_DISPLAY: state_d = ST_RUN;
                ST_RUN:         state_d = ST_RUN;
                default:        state_d = ST_ASSERT;
            endcase
        end

        enter = (state_d != state_q) || take_req;
        if (enter) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Reassertion is immediate; core/periph release lands one cycle into their stage.
        asserting     = state_d inside {ST_ASSERT, ST_WAIT_LOCK, ST_HOLD};
        rst_core_d    = asserting ||
                        !(state_q inside {ST_REL_CORE, ST_REL_PERIPH, ST_REL_DISPLAY, ST_RUN});
        rst_periph_d  = asserting || !(state_q inside {ST_REL_PERIPH, ST_REL_DISPLAY, ST_RUN});
        rst_display_d = (state_d != ST_RUN);
        seq_done_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge ext_reset) begin
        if (ext_reset) begin
            state_q       <= ST_ASSERT;
            cause_q       <= CAUSE_EXT;
            cnt_q         <= '0;
            rst_core_q    <= 1'b1;
            rst_periph_q  <= 1'b1;
            rst_display_q <= 1'b1;
            seq_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            cnt_q         <= cnt_d;
            rst_core_q    <= rst_core_d;
            rst_periph_q  <= rst_periph_d;
            rst_display_q <= rst_display_d;
            seq_done_q    <= seq_done_d;
        end
    end

    assign rst_core    = rst_core_q;
    assign rst_periph  = rst_periph_q;
    assign rst_display = rst_display_q;
    assign seq_done    = seq_done_q;
    assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer; watchdog cases follow RESET_SEQ_WDT_EN.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       ext_reset;
    logic       btn_reset;
    logic       sw_reset_req;
    logic       pll_locked;
    logic       wdt_kick;
    logic       rst_core, rst_periph, rst_display, seq_done;
    logic [1:0] reset_cause;
    logic [3:0] outs;

    int checks     = 0;
    int failures   = 0;
    int core_rises = 0;
    int r0;

    assign outs = {rst_core, rst_periph, rst_display, seq_done};

    reset_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (16),
        .STAGE_GAP      (4),
        .WDT_CYCLES     (64)
    ) dut (
        .clk         (clk),
        .ext_reset   (ext_reset),
        .btn_reset   (btn_reset),
        .sw_reset_req(sw_reset_req),
        .pll_locked  (pll_locked),
        .wdt_kick    (wdt_kick),
        .rst_core    (rst_core),
        .rst_periph  (rst_periph),
        .rst_display (rst_display),
        .seq_done    (seq_done),
        .reset_cause (reset_cause)
    );

    always #5 clk = ~clk;

    always @(posedge rst_core) core_rises++;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the negedge just after the HOLD-entry edge; ends just after RUN entry.
    task automatic expect_sequence(input string tag);
        step(16); check_eq({tag, "_hold_end"},    int'(outs), 'b1110);
        step(1);  check_eq({tag, "_core_rel"},    int'(outs), 'b0110);
        step(3);  check_eq({tag, "_core_gap"},    int'(outs), 'b0110);
        step(1);  check_eq({tag, "_periph_rel"},  int'(outs), 'b0010);
        step(3);  check_eq({tag, "_periph_gap"},  int'(outs), 'b0010);
        step(1);  check_eq({tag, "_display_rel"}, int'(outs), 'b0001);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ext_reset    = 1'b1;
        btn_reset    = 1'b0;
        sw_reset_req = 1'b0;
        pll_locked   = 1'b1;
        wdt_kick     = 1'b1;

        // Power-up
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", int'(outs), 'b1110);
        check_eq("reset_cause", int'(reset_cause), 0);
        ext_reset = 1'b0;
        step(1); check_eq("wait_lock_outs", int'(outs), 'b1110);
        step(1);
        expect_sequence("pwr");
        check_eq("pwr_cause", int'(reset_cause), 0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_eq("lock_lost_outs", int'(outs), 'b1110);
        end
        pll_locked = 1'b1;
        step(1);
        expect_sequence("relock");
        check_eq("relock_cause", int'(reset_cause), 0);

        // Button glitches alone
        r0 = core_rises;
        repeat (4) begin
            btn_reset = 1'b1; step(3);
            btn_reset = 1'b0; step(3);
        end
        step(20);
        check_eq("glitch_rises", core_rises - r0, 0);
        check_eq("glitch_outs", int'(outs), 'b0001);

        // Bounce then hold
        r0 = core_rises;
        repeat (3) begin
            btn_reset = 1'b1; step(3);
            btn_reset = 1'b0; step(3);
        end
        btn_reset = 1'b1;
        step(11); check_eq("btn_before_req", int'(outs), 'b0001);
        step(1);  check_eq("btn_req_outs", int'(outs), 'b1110);
        check_eq("btn_cause", int'(reset_cause), 1);
        btn_reset = 1'b0;
        step(1);

        // Software request in REL_PERIPH
        step(17); check_eq("sw_core_rel", int'(outs), 'b0110);
        step(4);  check_eq("sw_in_periph", int'(outs), 'b0010);
        check_eq("btn_one_req", core_rises - r0, 1);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check_eq("sw_outs", int'(outs), 'b1110);
        check_eq("sw_cause", int'(reset_cause), 2);
        step(1);
        expect_sequence("sw");
        check_eq("sw_cause_run", int'(reset_cause), 2);

        // Button edge and software request in the same cycle
        btn_reset = 1'b1;
        step(11); check_eq("simul_before", int'(outs), 'b0001);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check_eq("simul_outs", int'(outs), 'b1110);
        check_eq("simul_cause", int'(reset_cause), 1);
        btn_reset = 1'b0;
        step(1);
        expect_sequence("simul");

        // Watchdog: periodic kicks, then silence
        wdt_kick = 1'b0;
        r0 = core_rises;
        repeat (4) begin
            step(49);
            wdt_kick = 1'b1; step(1);
            wdt_kick = 1'b0;
        end
        check_eq("wdt_kicked_outs", int'(outs), 'b0001);
        check_eq("wdt_kicked_rises", core_rises - r0, 0);
        step(63); check_eq("wdt_before_timeout", int'(outs), 'b0001);
        step(1);
`ifdef RESET_SEQ_WDT_EN
        check_eq("wdt_timeout_outs", int'(outs), 'b1110);
        check_eq("wdt_cause", int'(reset_cause), 3);
`else
        check_eq("no_wdt_outs", int'(outs), 'b0001);
        check_eq("no_wdt_cause", int'(reset_cause), 1);
`endif

        // Asynchronous ext_reset mid-cycle
        #2 ext_reset = 1'b1;
        #1;
        check_eq("async_rst_outs", int'(outs), 'b1110);
        check_eq("async_rst_cause", int'(reset_cause), 0);
        step(2);
        ext_reset = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
